// File: rtl/layer_pkg.sv
// Shared helpers for the featuremap accumulation layers: width arithmetic, saturation and
// the leaky-ReLU slope.
package layer_pkg;

  localparam int unsigned LEAKY_SHIFT = 3;
  // Widest intermediate value the saturate helper accepts.
  localparam int unsigned SAT_MAX_W = 128;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Stage s of the adder tree carries one extra bit per level so nothing is truncated.
  function automatic int unsigned tree_stage_width(input int unsigned data_width,
                                                   input int unsigned stage);
    return data_width + stage + 1;
  endfunction

  // Clamp a sign-extended wide value to the signed range of a dw-bit word.
  function automatic logic signed [SAT_MAX_W-1:0] saturate(
      input logic signed [SAT_MAX_W-1:0] x, input int unsigned dw);
    logic signed [SAT_MAX_W-1:0] max_v;
    logic signed [SAT_MAX_W-1:0] min_v;
    max_v = $signed((SAT_MAX_W'(1) << (dw - 1)) - SAT_MAX_W'(1));
    min_v = ~max_v;
    if (x > max_v) return max_v;
    else if (x < min_v) return min_v;
    else return x;
  endfunction

endpackage

// File: rtl/fm_adder_tree.sv
// Registered pairwise reduction of NUM_CH signed lanes; one register stage per tree level,
// every stage gated by a shared enable and carrying its own valid bit.
module fm_adder_tree
  import layer_pkg::*;
#(
  parameter int unsigned NUM_CH     = 16,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned LEVELS    = clog2(NUM_CH),
  localparam int unsigned SUM_W     = DATA_WIDTH + LEVELS
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           en,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   lanes,
  input  logic                           lanes_valid,
  output logic signed [SUM_W-1:0]        sum,
  output logic                           sum_valid
);

  if (LEVELS == 0) begin : g_bypass
    assign sum       = $signed(lanes);
    assign sum_valid = lanes_valid;
  end else begin : g_tree
    for (genvar s = 0; s < LEVELS; s++) begin : g_stage
      localparam int unsigned N = NUM_CH >> (s + 1);
      localparam int unsigned W = tree_stage_width(DATA_WIDTH, s);

      logic vld_d;
      logic vld_q;

      if (s == 0) begin : g_vld_first
        assign vld_d = lanes_valid;
      end else begin : g_vld_next
        assign vld_d = g_stage[s-1].vld_q;
      end

      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
          vld_q <= 1'b0;
        end else if (en) begin
          vld_q <= vld_d;
        end
      end

      for (genvar i = 0; i < N; i++) begin : g_node
        logic signed [W-1:0] sum_d;
        logic signed [W-1:0] sum_q;

        if (s == 0) begin : g_leaf
          assign sum_d = W'($signed(lanes[2*i*DATA_WIDTH +: DATA_WIDTH]))
                       + W'($signed(lanes[(2*i+1)*DATA_WIDTH +: DATA_WIDTH]));
        end else begin : g_inner
          assign sum_d = W'(g_stage[s-1].g_node[2*i].sum_q)
                       + W'(g_stage[s-1].g_node[2*i+1].sum_q);
        end

        always_ff @(posedge Clk or posedge Rst) begin
          if (Rst) begin
            sum_q <= '0;
          end else if (en) begin
            sum_q <= sum_d;
          end
        end
      end
    end

    assign sum       = g_stage[LEVELS-1].g_node[0].sum_q;
    assign sum_valid = g_stage[LEVELS-1].vld_q;
  end

endmodule

// File: rtl/layer_featuremap_accum.sv
// Reduces NUM_CH Conv2D3x3 partials to one output pixel: adder tree, bias + saturate,
// activation (leaky ReLU when LAYER_FEATUREMAP_LEAKY_RELU_EN is defined), row/frame markers.
module layer_featuremap_accum
  import layer_pkg::*;
#(
  parameter int unsigned                 NUM_CH     = 16,
  parameter int unsigned                 DATA_WIDTH = 32,
  parameter int unsigned                 FRAC_BITS  = 16,
  parameter int unsigned                 IMG_SIZE   = 208,
  parameter logic signed [DATA_WIDTH-1:0] BIAS      = '0
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic                         last_col,
  output logic                         last_frame
);

  localparam int unsigned LEVELS = clog2(NUM_CH);
  localparam int unsigned SUM_W  = DATA_WIDTH + LEVELS;
  localparam int unsigned BIAS_W = SUM_W + 1;
  localparam int unsigned POS_W  = (IMG_SIZE > 1) ? clog2(IMG_SIZE) : 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(IMG_SIZE - 1);

  if ((NUM_CH != (1 << LEVELS)) || (FRAC_BITS >= DATA_WIDTH) || (IMG_SIZE == 0)) begin : g_param_check
    $error("layer_featuremap_accum: bad NUM_CH/FRAC_BITS/IMG_SIZE");
  end

  // Whole pipeline freezes while the output word waits for the consumer.
  logic stall;
  logic en;
  assign stall     = valid_out && !ready_in;
  assign en        = !stall;
  assign ready_out = en;

  logic signed [SUM_W-1:0] tree_sum;
  logic                    tree_valid;

  fm_adder_tree #(
    .NUM_CH     (NUM_CH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tree (
    .Clk         (Clk),
    .Rst         (Rst),
    .en          (en),
    .lanes       (data_in),
    .lanes_valid (valid_in),
    .sum         (tree_sum),
    .sum_valid   (tree_valid)
  );

  logic signed [BIAS_W-1:0]     biased;
  logic signed [DATA_WIDTH-1:0] bias_d;
  logic signed [DATA_WIDTH-1:0] bias_q;
  logic                         bias_vld_q;

  always_comb begin
    biased = BIAS_W'(tree_sum) + BIAS_W'(BIAS);
    bias_d = DATA_WIDTH'(saturate(SAT_MAX_W'(biased), DATA_WIDTH));
  end

  logic signed [DATA_WIDTH-1:0] act_d;

  always_comb begin
    act_d = bias_q;
`ifdef LAYER_FEATUREMAP_LEAKY_RELU_EN
    if (bias_q[DATA_WIDTH-1]) begin
      act_d = bias_q >>> LEAKY_SHIFT;
    end
`endif
  end

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      bias_q     <= '0;
      bias_vld_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else if (en) begin
      bias_q     <= bias_d;
      bias_vld_q <= tree_valid;
      data_q     <= act_d;
      valid_q    <= bias_vld_q;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;

  // Output position; advances only when the consumer takes a pixel.
  logic [POS_W-1:0] col_d;
  logic [POS_W-1:0] col_q;
  logic [POS_W-1:0] row_d;
  logic [POS_W-1:0] row_q;
  logic             at_last_col;
  logic             at_last_row;

  always_comb begin
    at_last_col = (col_q == LAST_POS);
    at_last_row = (row_q == LAST_POS);
    col_d       = col_q;
    row_d       = row_q;
    if (valid_q && ready_in) begin
      if (at_last_col) begin
        col_d = '0;
        row_d = at_last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign last_col   = valid_q && at_last_col;
  assign last_frame = last_col && at_last_row;

endmodule

// File: tb/tb_layer_featuremap_accum.sv
// Self-checking bench for layer_featuremap_accum (NUM_CH=16, IMG_SIZE=4, BIAS=1.0).
module tb_layer_featuremap_accum;

  localparam int NCH = 16;
  localparam int DW  = 32;
  localparam int IMG = 4;
  localparam logic signed [DW-1:0] BIAS_V = 32'sh0001_0000;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH*DW-1:0] data_in = '0;
  logic              valid_in = 1'b0;
  logic              ready_out;
  logic [DW-1:0]     data_out;
  logic              valid_out;
  logic              ready_in = 1'b1;
  logic              last_col;
  logic              last_frame;

  layer_featuremap_accum #(
    .NUM_CH     (NCH),
    .DATA_WIDTH (DW),
    .FRAC_BITS  (16),
    .IMG_SIZE   (IMG),
    .BIAS       (BIAS_V)
  ) dut (
    .Clk        (clk),
    .Rst        (rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .last_col   (last_col),
    .last_frame (last_frame)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: sum all lanes plus bias exactly, clamp to 32-bit signed, then activation.
  function automatic logic [DW-1:0] model_pixel(input logic [NCH*DW-1:0] v);
    longint acc;
    logic [DW-1:0] lane;
    acc = longint'(BIAS_V);
    for (int k = 0; k < NCH; k++) begin
      lane = v[k*DW +: DW];
      acc += longint'($signed(lane));
    end
    if (acc > MAXV) acc = MAXV;
    else if (acc < MINV) acc = MINV;
`ifdef LAYER_FEATUREMAP_LEAKY_RELU_EN
    if (acc < 0) acc = acc >>> 3;
`endif
    return acc[DW-1:0];
  endfunction

  function automatic logic [NCH*DW-1:0] splat(input logic [DW-1:0] lane);
    logic [NCH*DW-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*DW +: DW] = lane;
    return v;
  endfunction

  // Distinct stream pixels, alternating sign so both activation branches are hit.
  function automatic logic [NCH*DW-1:0] pix(input int p);
    logic [NCH*DW-1:0] v;
    logic [DW-1:0] lane;
    for (int k = 0; k < NCH; k++) begin
      lane = DW'(((p + 1) << 16) + k * 256);
      if (p % 2 == 1) lane = -lane;
      v[k*DW +: DW] = lane;
    end
    return v;
  endfunction

  // ---------------- compare process ----------------
  logic [DW-1:0] exp_q[$];
  int            out_idx = 0;
  int            lf_idx[$];
  int            stall_cycles = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [1:0]    prev_marks;
  logic [DW-1:0] e;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      out_idx    = 0;
      prev_stall = 1'b0;
      check("reset_valid_out", 64'(valid_out), 64'd0);
      check("reset_ready_out", 64'(ready_out), 64'd1);
    end else begin
      check("ready_out", 64'(ready_out), 64'(!(valid_out && !ready_in)));
      if (prev_stall) begin
        check("hold_valid", 64'(valid_out), 64'd1);
        check("hold_data", 64'(data_out), 64'(prev_data));
        check("hold_markers", 64'({last_col, last_frame}), 64'(prev_marks));
      end
      if (!valid_out) check("idle_markers", 64'({last_col, last_frame}), 64'd0);
      if (!ready_out) stall_cycles++;
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stale_output: got %0h, expected no output", data_out);
        end else begin
          e = exp_q.pop_front();
          check("data_out", 64'(data_out), 64'(e));
          check("last_col", 64'(last_col), 64'((out_idx % IMG) == IMG - 1));
          check("last_frame", 64'(last_frame), 64'((out_idx % (IMG * IMG)) == IMG * IMG - 1));
          if (last_frame) lf_idx.push_back(out_idx);
          out_idx++;
        end
      end
      if (valid_in && ready_out) exp_q.push_back(model_pixel(data_in));
      prev_stall = valid_out && !ready_in;
      prev_data  = data_out;
      prev_marks = {last_col, last_frame};
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [NCH*DW-1:0] v);
    bit done;
    done     = 1'b0;
    data_in  = v;
    valid_in = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      done = ready_out;
      tick();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no acceptance, expected ready_out within 50 cycles");
    end
    valid_in = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) tick();
    check({"drain_", name}, 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
  endtask

  task automatic directed(input string name, input logic [DW-1:0] lane, input logic [DW-1:0] exp);
    logic [NCH*DW-1:0] v;
    int c0;
    bit seen;
    v    = splat(lane);
    seen = 1'b0;
    check({name, "_model"}, 64'(model_pixel(v)), 64'(exp));
    c0 = cyc;
    send(v);
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (valid_out) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no valid_out, expected one within 20 cycles", name);
    end else begin
      check(name, 64'(data_out), 64'(exp));
      check({name, "_latency"}, 64'(cyc - c0), 64'd6);
    end
    drain(name);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) tick();
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_markers", 64'({last_col, last_frame}), 64'd0);
    rst = 1'b0;
    tick();

`ifdef LAYER_FEATUREMAP_LEAKY_RELU_EN
    directed("ones",     32'h0001_0000, 32'h0011_0000);
    directed("pos_sat",  32'h7FFF_FFFF, 32'h7FFF_FFFF);
    directed("neg_sat",  32'h8000_0000, 32'hF000_0000);
    directed("neg_ones", 32'hFFFF_0000, 32'hFFFE_2000);
`else
    directed("ones",     32'h0001_0000, 32'h0011_0000);
    directed("pos_sat",  32'h7FFF_FFFF, 32'h7FFF_FFFF);
    directed("neg_sat",  32'h8000_0000, 32'h8000_0000);
    directed("neg_ones", 32'hFFFF_0000, 32'hFFF1_0000);
`endif

    // Stream of 20 pixels; consumer refuses for 3 cycles while pixel 7 is presented.
    begin
      int base;
      base         = out_idx;
      stall_cycles = 0;
      fork
        begin
          for (int p = 0; p < 20; p++) send(pix(p));
        end
        begin
          bit hit;
          hit = 1'b0;
          for (int t = 0; t < 200 && !hit; t++) begin
            @(negedge clk);
            if (valid_out && ready_in && out_idx == base + 6) hit = 1'b1;
          end
          check("stall_trigger", 64'(hit), 64'd1);
          tick();
          ready_in = 1'b0;
          repeat (3) tick();
          ready_in = 1'b1;
        end
      join
      drain("stream");
      check("stream_count", 64'(out_idx - base), 64'd20);
      check("stall_cycles", 64'(stall_cycles), 64'd3);
    end

    // Two full 4x4 frames back-to-back from a clean reset.
    do_reset();
    lf_idx.delete();
    for (int p = 0; p < 32; p++) send(pix(p + 3));
    drain("frames");
    check("frame_outputs", 64'(out_idx), 64'd32);
    check("frame_lf_count", 64'(lf_idx.size()), 64'd2);
    if (lf_idx.size() == 2) begin
      check("frame_lf_first", 64'(lf_idx[0]), 64'd15);
      check("frame_lf_second", 64'(lf_idx[1]), 64'd31);
    end

    // Asynchronous reset with pixels still inside the pipeline.
    for (int p = 0; p < 8; p++) send(pix(p + 40));
    check("pre_reset_valid", 64'(valid_out), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_valid_out", 64'(valid_out), 64'd0);
    check("async_data_out", 64'(data_out), 64'd0);
    check("async_markers", 64'({last_col, last_frame}), 64'd0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    for (int p = 0; p < 4; p++) send(pix(p + 60));
    drain("post_reset");
    check("post_reset_count", 64'(out_idx), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/layer_featuremap_accum.md
Name: layer_featuremap_accum

Overview:
Parametrised successor to the per-layer featuremap blocks.
- Takes the NUM_CH per-input-channel Conv2D3x3 partial results for one output pixel.
- Reduces them through a registered adder tree, adds a bias, saturates, and optionally applies leaky ReLU.
- Emits one output-featuremap pixel with row/frame markers.
- Sits between the Conv2D3x3 lane array and the next layer's line buffers. Adds ready/valid backpressure, which the lane array lacks.

Parameters:
- NUM_CH, 16: input channel lanes; power of 2, ≥1.
- DATA_WIDTH, 32: lane and output width; signed two's complement fixed-point.
- FRAC_BITS, 16: fractional bits of lane, bias and output (same Q format).
- IMG_SIZE, 208: featuremap width and height in pixels.
- BIAS, 0: signed DATA_WIDTH bias in the same Q format.

Ports:
- Clk  in  1  clock.
- Rst  in  1  asynchronous, active-high reset.
- data_in  in  NUM_CH*DATA_WIDTH  packed lanes; lane k = data_in[(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
- valid_in  in  1  data_in valid.
- ready_out  out  1  block can accept data_in this cycle.
- data_out  out  DATA_WIDTH  output pixel.
- valid_out  out  1  data_out valid.
- ready_in  in  1  downstream accepts data_out.
- last_col  out  1  data_out is the last pixel of a row.
- last_frame  out  1  data_out is the last pixel of the frame.

Behaviour:
- Reset values: data_out=0, valid_out=0, last_col=0, last_frame=0; all pipeline valids 0; col/row counters 0. ready_out is 1 after reset.
- Clk and Rst: single clock Clk; Rst is asynchronous and active-high.
- Handshakes: input transfer occurs on valid_in&&ready_out; output transfer occurs on valid_out&&ready_in.
- Stall rule: stall = valid_out && !ready_in.
  - ready_out = !stall.
  - During stall every pipeline register, including data_out/valid_out/markers, holds.
  - No bubble collapsing is required.
- Latency: L = log2(NUM_CH) + 2 non-stalled cycles, i.e. tree stages + bias/saturate stage + activation stage. L=6 for NUM_CH=16 and L=2 for NUM_CH=1.
- Throughput: one pixel per cycle when not stalled.
- Adder tree:
  - Stage s holds NUM_CH/2^(s+1) sums of width DATA_WIDTH+s+1, sign-extended.
  - No truncation inside the tree.
- Bias stage: sum + sign-extended BIAS, then saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Activation stage: see Optional Feature. Always registered.
- Valid pipeline: a valid bit travels with each stage. A bubble (valid_in=0) propagates as valid=0 and its data is don't-care.
- Position counters:
  - col and row advance on each output transfer only.
  - last_col = (col==IMG_SIZE-1) and last_frame = last_col && (row==IMG_SIZE-1), combinational from the counters, qualified by valid_out.
  - col wraps to 0 after IMG_SIZE-1 and row increments. row wraps to 0 after the last_frame transfer.
- Reset mid-operation: in-flight pixels are discarded, counters return to 0, and there is no output glitch beyond the async clear.

Optional Feature:
- Macro: LAYER_FEATUREMAP_LEAKY_RELU_EN.
- Defined: data_out = x ≥ 0 ? x : x>>>3 (arithmetic shift, slope 0.125).
- Undefined: data_out = x (identity). The stage register is retained, so L is unchanged.

Decomposition:
- Shared package layer_pkg:
  - clog2 function.
  - saturate function (wide signed → DATA_WIDTH).
  - LEAKY_SHIFT=3 constant.
  - Tree-stage width helper.
- Sub-module fm_adder_tree:
  - Generic registered pairwise reduction with a per-stage valid and a shared enable (!stall).
  - Instantiated once; bias, activation, handshake and counters stay in the top module.

Test Plan:
- 16 lanes each 0x00010000 (1.0), BIAS=0, ready_in=1 → data_out=0x00100000 (16.0), valid_out exactly 6 cycles after the input.
- All lanes 0x7FFFFFFF, BIAS=0x00010000 → data_out=0x7FFFFFFF (saturated). All lanes 0x80000000 with macro undefined → 0x80000000.
- All lanes 0xFFFF0000 (-1.0): macro defined → 0xFFFE0000 (-2.0); undefined → 0xFFF00000 (-16.0).
- Continuous stream of pixels 0..19 with ready_in low for 3 cycles at pixel 7 → ready_out low for exactly those 3 cycles; output sequence complete, in order, no duplicates; data_out held stable while stalled.
- IMG_SIZE=4, 32 back-to-back pixels → last_col on pixels 3,7,11,15,19,…; last_frame on pixels 15 and 31; counters wrap cleanly.
- Rst pulsed asynchronously with 4 pixels in flight → valid_out=0 immediately, no stale outputs afterwards, and the next pixel is treated as col=0,row=0.
